alu_pipe: RTL and testbench

Parametrised, handshaked successor to the single-cycle datapath ALU. It registers operands and results, adds an iterative shift-add multiplier and a signed-overflow flag, and carries a pass-through tag so the issuing stage can match each result to its instruction. It sits between the register-read stage and writeback. Valid/ready handshakes on both sides let writeback stall the ALU without losing data.

---
 rtl/alu_pipe.sv | 174 +++++++++++++++++
 tb/tb_alu_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked, registered ALU with iterative shift-add multiplier and pass-through tag
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    input  logic [3:0]       in_op_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_result_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             out_carry_o,
    output logic             out_zero_o,
    output logic             out_sign_o,
    output logic             out_ovf_o
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic       IDLE   = 1'b0;
    localparam logic       MUL    = 1'b1;
    localparam logic [3:0] OP_MOV = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_NEG = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SRL = 4'd9;
    localparam logic [3:0] OP_SRA = 4'd10;
    localparam logic [3:0] OP_SLT = 4'd11;
    localparam logic [3:0] OP_SLTU = 4'd12;
    localparam logic [3:0] OP_MUL = 4'd13;

    logic             state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TAG_W-1:0] mtag_q, mtag_d, tag_q, tag_d;
    logic             vld_q, vld_d, carry_q, carry_d, zero_q, zero_d;
    logic             sign_q, sign_d, ovf_q, ovf_d;

    logic [WIDTH-1:0]        x, y, alu_res, acc_nx;
    logic signed [WIDTH-1:0] a_s;
    logic [WIDTH:0]          sum;
    logic [SW-1:0]           sh;
    logic                    cin, arith, alu_c, alu_v;

    assign in_ready_o   = (state_q == IDLE) && (!vld_q || out_ready_i);
    assign out_valid_o  = vld_q;
    assign out_result_o = res_q;
    assign out_tag_o    = tag_q;
    assign out_carry_o  = carry_q;
    assign out_zero_o   = zero_q;
    assign out_sign_o   = sign_q;
    assign out_ovf_o    = ovf_q;
    assign a_s          = in_a_i;
    assign sh           = in_b_i[SW-1:0];
    assign acc_nx       = acc_q + (b_q[0] ? a_q : '0);

    // Single-cycle ALU: one shared adder serves ADD, SUB (a+~b+1) and NEG (0+~b+1)
    always_comb begin
        x     = (in_op_i == OP_NEG) ? '0 : in_a_i;
        y     = (in_op_i == OP_ADD) ? in_b_i : ~in_b_i;
        cin   = (in_op_i != OP_ADD);
        sum   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        arith = in_op_i inside {OP_ADD, OP_SUB, OP_NEG};
        case (in_op_i)
            OP_MOV:  alu_res = in_a_i;
            OP_ADD, OP_SUB, OP_NEG: alu_res = sum[WIDTH-1:0];
            OP_AND:  alu_res = in_a_i & in_b_i;
            OP_OR:   alu_res = in_a_i | in_b_i;
            OP_XOR:  alu_res = in_a_i ^ in_b_i;
            OP_NOT:  alu_res = ~in_b_i;
            OP_SLL:  alu_res = in_a_i << sh;
            OP_SRL:  alu_res = in_a_i >> sh;
            OP_SRA:  alu_res = a_s >>> sh;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(in_a_i) < $signed(in_b_i)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, in_a_i < in_b_i};
            default: alu_res = '0;
        endcase
        alu_c = arith ? sum[WIDTH] : 1'b0;
        alu_v = arith && (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    end

    // Next state: accept/drain in IDLE, one shift-add step per cycle in MUL
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mtag_d  = mtag_q;
        res_d   = res_q;
        tag_d   = tag_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        sign_d  = sign_q;
        ovf_d   = ovf_q;
        vld_d   = vld_q && !out_ready_i;
        if (state_q == IDLE) begin
            if (in_valid_i && in_ready_o && in_op_i == OP_MUL) begin
                a_d     = in_a_i;
                b_d     = in_b_i;
                mtag_d  = in_tag_i;
                acc_d   = '0;
                cnt_d   = CW'(WIDTH);
                state_d = MUL;
            end else if (in_valid_i && in_ready_o) begin
                res_d   = alu_res;
                tag_d   = in_tag_i;
                carry_d = alu_c;
                zero_d  = (alu_res == '0);
                sign_d  = alu_res[WIDTH-1];
                ovf_d   = alu_v;
                vld_d   = 1'b1;
            end
        end else begin
            acc_d = acc_nx;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                res_d   = acc_nx;
                tag_d   = mtag_q;
                carry_d = 1'b0;
                zero_d  = (acc_nx == '0);
                sign_d  = acc_nx[WIDTH-1];
                ovf_d   = 1'b0;
                vld_d   = 1'b1;
                state_d = IDLE;
            end
        end
    end

    // State and output registers; reset aborts any multiply in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            mtag_q  <= '0;
            res_q   <= '0;
            tag_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mtag_q  <= mtag_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random scoreboard bench for alu_pipe
module tb_alu_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0, in_b = '0;
    logic [3:0]  in_op = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_carry, out_zero, out_sign, out_ovf;

    typedef struct packed {
        logic [4:0]  tag;
        logic [35:0] e;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   passed = 0;

    alu_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a_i(in_a), .in_b_i(in_b), .in_op_i(in_op), .in_tag_i(in_tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_result_o(out_result), .out_tag_o(out_tag),
        .out_carry_o(out_carry), .out_zero_o(out_zero),
        .out_sign_o(out_sign), .out_ovf_o(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // {carry, zero, sign, ovf, result}
    function automatic logic [35:0] ex(input logic [31:0] r, input logic c, z, s, v);
        return {c, z, s, v, r};
    endfunction

    function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a, b);
        logic [31:0] r;
        logic [63:0] w;
        logic        c, v;
        r = '0; c = 1'b0; v = 1'b0; w = '0;
        case (op)
            4'd0:  r = a;
            4'd1:  begin w = {32'b0, a} + {32'b0, b}; r = w[31:0]; c = w[32];
                         v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd2:  begin r = a - b; c = (a >= b); v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd3:  begin r = -b; c = (b == 0); v = (b == 32'h8000_0000); end
            4'd4:  r = a & b;
            4'd5:  r = a | b;
            4'd6:  r = a ^ b;
            4'd7:  r = ~b;
            4'd8:  r = a << b[4:0];
            4'd9:  r = a >> b[4:0];
            4'd10: r = $signed(a) >>> b[4:0];
            4'd11: r = {31'b0, $signed(a) < $signed(b)};
            4'd12: r = {31'b0, a < b};
            4'd13: begin w = {32'b0, a} * {32'b0, b}; r = w[31:0]; end
            default: r = '0;
        endcase
        return {c, r == 0, r[31], v, r};
    endfunction

    // Scoreboard: pop and compare each result that will transfer on the coming edge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                check("result", out_result, cur.e[31:0]);
                check("tag", out_tag, cur.tag);
                check("flags", {out_carry, out_zero, out_sign, out_ovf}, cur.e[35:32]);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge (or after MUL completes when chk)
    task automatic issue(input logic [3:0] op, input logic [31:0] a, b, input logic [4:0] tag,
                         input logic [35:0] e, input bit chk);
        int n, busy;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("accept", in_ready, 1);
        sb.push_back('{tag: tag, e: e});
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (chk && op != 4'd13) check("latency", out_valid, 1);
        else if (chk) begin
            busy = 0;
            repeat (32) begin
                @(negedge clk);
                if (!in_ready && !out_valid) busy++;
            end
            check("mul_busy", busy, 32);
            @(negedge clk);
            check("mul_done", out_valid, 1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n, stable;
        logic [3:0]  op;
        logic [31:0] a, b;
        #2 rst_n = 1'b0;
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_result", out_result, 0);
        check("rst_tag", out_tag, 0);
        check("rst_flags", {out_carry, out_zero, out_sign, out_ovf}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", in_ready, 1);
        @(posedge clk); #1;

        issue(4'd1, 32'hFFFF_FFFF, 32'd1, 5'd1, ex(32'h0, 1, 1, 0, 0), 1);
        issue(4'd2, 32'h8000_0000, 32'd1, 5'd2, ex(32'h7FFF_FFFF, 1, 0, 0, 1), 1);
        issue(4'd2, 32'd5, 32'd7, 5'd3, ex(32'hFFFF_FFFE, 0, 0, 1, 0), 1);
        issue(4'd10, 32'h8000_0000, 32'd36, 5'd4, ex(32'hF800_0000, 0, 0, 1, 0), 1);
        issue(4'd9, 32'h8000_0000, 32'd36, 5'd5, ex(32'h0800_0000, 0, 0, 0, 0), 1);
        issue(4'd11, 32'hFFFF_FFFF, 32'd1, 5'd6, ex(32'h1, 0, 0, 0, 0), 1);
        issue(4'd12, 32'hFFFF_FFFF, 32'd1, 5'd7, ex(32'h0, 0, 1, 0, 0), 1);
        issue(4'd3, 32'd0, 32'h8000_0000, 5'd8, ex(32'h8000_0000, 0, 0, 1, 1), 1);
        issue(4'd3, 32'd9, 32'd0, 5'd9, ex(32'h0, 1, 1, 0, 0), 1);
        issue(4'd14, 32'd5, 32'd3, 5'd10, ex(32'h0, 0, 1, 0, 0), 1);
        issue(4'd13, 32'h0001_2345, 32'h100, 5'd7, ex(32'h0123_4500, 0, 0, 0, 0), 1);
        issue(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, ex(32'h1, 0, 0, 0, 0), 1);

        // Backpressure: ADD result held, XOR waits, then both leave in order
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(4'd1, 32'd1, 32'd2, 5'd12, ex(32'h3, 0, 0, 0, 0), 1);
        fork
            issue(4'd6, 32'hF0, 32'hFF, 5'd13, ex(32'h0F, 0, 0, 0, 0), 1);
            begin
                stable = 0;
                repeat (3) begin
                    @(negedge clk);
                    if (out_valid && out_result == 32'd3 && out_tag == 5'd12 && !in_ready) stable++;
                end
                check("bp_hold", stable, 3);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join

        // Random sweep against the reference model
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            issue(op, a, b, 5'(i), model(op, a, b), 1);
        end

        // Reset in the middle of a multiply
        @(posedge clk); #1;
        issue(4'd13, 32'd3, 32'd5, 5'd20, ex(32'd15, 0, 0, 0, 0), 0);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("abort_valid", out_valid, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", in_ready, 1);
        n = 0;
        repeat (35) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("abort_no_pulse", n, 0);
        @(posedge clk); #1;
        issue(4'd1, 32'd2, 32'd2, 5'd21, ex(32'd4, 0, 0, 0, 0), 1);

        n = 0;
        while (sb.size() > 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
